// File: rtl/ram_2d_64x32x8_if.sv
// Single-port access bus for the 64x32 byte RAM: command/address/data from the
// master, registered read data back from the RAM.
interface ram_2d_64x32x8_if #(
  parameter int ROWS  = 64,
  parameter int COLS  = 32,
  parameter int WIDTH = 8
);
  localparam int AW_A = $clog2(ROWS);
  localparam int AW_B = $clog2(COLS);

  logic             cs;
  logic             wr;
  logic [WIDTH-1:0] d_in;
  logic [AW_A-1:0]  add_a;
  logic [AW_B-1:0]  add_b;
  logic [WIDTH-1:0] d_out;

  modport master (output cs, wr, d_in, add_a, add_b, input d_out);
  modport slave  (input cs, wr, d_in, add_a, add_b, output d_out);
endinterface

// File: rtl/ram_2d_64x32x8.sv
// 64x32 byte single-port synchronous RAM addressed by (row, column), with a
// registered read port. Only the output register is reset; storage is retained.
module ram_2d_64x32x8 #(
  parameter int ROWS  = 64,
  parameter int COLS  = 32,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_2d_64x32x8_if.slave       bus
);
  logic [WIDTH-1:0] mem [ROWS][COLS];
  logic [WIDTH-1:0] rd_q;

  logic wr_en, rd_en;
  assign wr_en = bus.cs &  bus.wr;
  assign rd_en = bus.cs & ~bus.wr;

  // No reset on the array so it maps to block RAM; rst_n only masks the
  // write enable so edges during reset cannot corrupt retained contents.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[bus.add_a][bus.add_b] <= bus.d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_q <= '0;
    else if (rd_en) rd_q <= mem[bus.add_a][bus.add_b];
  end

  assign bus.d_out = rd_q;
endmodule

// File: tb/tb_ram_2d_64x32x8.sv
// Randomized bench for ram_2d_64x32x8: flat-array reference model, per-cycle
// output compare, and directed literal checks for the key scenarios.
module tb_ram_2d_64x32x8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_2d_64x32x8_if bus ();
  ram_2d_64x32x8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference model: flat 2048-byte store plus the value d_out must show.
  logic [7:0] model [2048];
  bit         written [2048];
  logic [7:0] exp_q = 8'h00;
  bit         exp_known = 1'b1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) written[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q = 8'h00;
        exp_known = 1'b1;
      end else if (bus.cs === 1'b1) begin
        if (bus.wr === 1'b1) begin
          model[int'(bus.add_a) * 32 + int'(bus.add_b)]   = bus.d_in;
          written[int'(bus.add_a) * 32 + int'(bus.add_b)] = 1'b1;
        end else begin
          exp_q     = model[int'(bus.add_a) * 32 + int'(bus.add_b)];
          exp_known = written[int'(bus.add_a) * 32 + int'(bus.add_b)];
        end
      end
    end
  end

  // Per-cycle compare, well after the edge so both DUT and model have settled.
  initial forever begin
    @(posedge clk);
    #2;
    if (exp_known) chk("cycle_dout", bus.d_out, exp_q);
  end

  task automatic drive(input logic c, input logic w, input int a, input int b, input logic [7:0] d);
    bus.cs = c; bus.wr = w; bus.add_a = 6'(a); bus.add_b = 5'(b); bus.d_in = d;
    @(negedge clk);
  endtask

  task automatic wr_op(input int a, input int b, input logic [7:0] d);
    drive(1'b1, 1'b1, a, b, d);
  endtask

  task automatic rd_op(input int a, input int b);
    drive(1'b1, 1'b0, a, b, 8'h00);
  endtask

  logic [7:0] sweep_data [2048];

  initial begin
    bus.cs = 1'b0; bus.wr = 1'b0; bus.add_a = '0; bus.add_b = '0; bus.d_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", bus.d_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic write/read
    wr_op(3, 7, 8'hA5);
    rd_op(3, 7);
    chk("basic_rd", bus.d_out, 8'hA5);

    // 2: 2D distinctness
    wr_op(1, 0, 8'h11);
    wr_op(0, 1, 8'h22);
    wr_op(63, 31, 8'hFF);
    wr_op(0, 0, 8'h00);
    rd_op(1, 0);   chk("rd_1_0",   bus.d_out, 8'h11);
    rd_op(0, 1);   chk("rd_0_1",   bus.d_out, 8'h22);
    rd_op(63, 31); chk("rd_63_31", bus.d_out, 8'hFF);
    rd_op(0, 0);   chk("rd_0_0",   bus.d_out, 8'h00);

    // 3: chip-select gating
    wr_op(10, 10, 8'h3C);
    rd_op(10, 10);
    repeat (4) drive(1'b0, 1'b1, 10, 10, 8'hC3);
    chk("cs_idle_hold", bus.d_out, 8'h3C);
    rd_op(10, 10);
    chk("cs_gated_rd", bus.d_out, 8'h3C);

    // 6: write then read on adjacent edges
    rd_op(3, 7);
    wr_op(20, 4, 8'h5A);
    chk("wr_holds_dout", bus.d_out, 8'hA5);
    rd_op(20, 4);
    chk("adj_rd", bus.d_out, 8'h5A);

    // 5: reset behaviour
    wr_op(5, 5, 8'h7E);
    rd_op(5, 5);
    chk("pre_reset_rd", bus.d_out, 8'h7E);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.add_a = 6'd5; bus.add_b = 5'd5; bus.d_in = 8'h99;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", bus.d_out, 8'h00);
    repeat (3) @(negedge clk);
    chk("in_reset", bus.d_out, 8'h00);
    bus.cs = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd_op(5, 5);
    chk("retained_after_reset", bus.d_out, 8'h7E);

    // 4: full sweep with random data
    for (int i = 0; i < 2048; i++) begin
      sweep_data[i] = 8'($urandom);
      wr_op(i / 32, i % 32, sweep_data[i]);
    end
    for (int i = 0; i < 2048; i++) begin
      rd_op(i / 32, i % 32);
      if (bus.d_out !== sweep_data[i]) chk("sweep_rd", bus.d_out, sweep_data[i]);
      else checks++;
    end

    // Random mixed traffic including idle cycles with junk on the bus
    for (int n = 0; n < 600; n++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 63),
            $urandom_range(0, 31), 8'($urandom));

    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
